// File: rtl/cache_miss_ctrl_pkg.sv
// Shared field widths, metadata layout, FSM encoding and debug view for the
// cache miss controller.
package cache_miss_ctrl_pkg;

  localparam int ADDR_W   = 16;
  localparam int TAG_W    = 6;
  localparam int SET_W    = 6;
  localparam int OFF_W    = 4;
  localparam int NUM_SETS = 1 << SET_W;
  localparam int META_W   = 8;
  localparam int DATA_W   = 16;
  localparam int CNT_W    = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FILL    = 2'd1,
    ST_META_WR = 2'd2
  } state_e;

  // Metadata byte: tag [7:2], LRU [1] (1 = least recently used), valid [0].
  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic             lru;
    logic             valid;
  } meta_t;

  typedef struct packed {
    state_e            state;
    logic              victim;
    logic [CNT_W-1:0]  issue_cnt;
    logic [CNT_W-1:0]  recv_cnt;
    logic              fill_overrun;
    logic [ADDR_W-1:0] miss_addr;
  } dbg_t;

  // Empty ways are filled first, then the way flagged least recent.
  function automatic logic pick_victim(input meta_t m0, input meta_t m1);
    if (!m0.valid)   return 1'b0;
    else if (!m1.valid) return 1'b1;
    else if (m0.lru) return 1'b0;
    else if (m1.lru) return 1'b1;
    else             return 1'b0;
  endfunction

  function automatic logic [META_W-1:0] mru_meta(input logic [TAG_W-1:0] tag);
    return {tag, 2'b11};
  endfunction

endpackage

// File: rtl/cache_miss_ctrl_fill_counter.sv
// Small word counter with synchronous clear and count enable; used to track
// issued reads and received words during a block fill.
module fill_counter
  import cache_miss_ctrl_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)     cnt_d = '0;
    else if (en) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/cache_miss_ctrl.sv
// Two-way cache miss controller: hit detection and MRU update, block fill from
// memory into the chosen victim way, and the closing metadata write.
module cache_miss_ctrl
  import cache_miss_ctrl_pkg::*;
#(
  parameter int MEM_LAT   = 4,
  parameter int BLK_WORDS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [META_W-1:0]   meta0,
  input  logic [META_W-1:0]   meta1,
  output logic                hit,
  output logic                hit_way,
  output logic                stall,
  output logic [NUM_SETS-1:0] set_en,
  output logic                meta_wr0,
  output logic                meta_wr1,
  output logic [META_W-1:0]   meta_din,
  output logic                mem_rd,
  output logic [ADDR_W-1:0]   mem_addr,
  input  logic                mem_vld,
  input  logic [DATA_W-1:0]   mem_data,
  output logic                dwr_en,
  output logic                dwr_way,
  output logic [CNT_W-1:0]    dwr_off,
  output logic [DATA_W-1:0]   dwr_data,
  output dbg_t                dbg
);

  localparam logic [CNT_W-1:0] LAST_WORD    = CNT_W'(BLK_WORDS - 1);
  localparam logic [7:0]       FILL_CYC_MAX = 8'(BLK_WORDS + MEM_LAT - 1);

  state_e            state_q, state_d;
  logic              victim_q, victim_d;
  logic [ADDR_W-1:0] miss_addr_q, miss_addr_d;
  logic              mem_rd_q, mem_rd_d;
  logic [7:0]        fill_cyc_q, fill_cyc_d;
  logic              overrun_q, overrun_d;

  logic [CNT_W-1:0]  issue_cnt;
  logic [CNT_W-1:0]  recv_cnt;
  logic              cnt_clr;
  logic              issue_en;
  logic              recv_en;

  meta_t             m0, m1;
  logic [TAG_W-1:0]  req_tag;
  logic [SET_W-1:0]  req_set;
  logic [TAG_W-1:0]  miss_tag;
  logic [SET_W-1:0]  miss_set;
  logic              hit0, hit1;
  logic              in_idle, in_fill, in_meta;
  logic              miss_start;
  logic              idle_hit;
  logic              last_rx;

  assign m0       = meta0;
  assign m1       = meta1;
  assign req_tag  = req_addr[ADDR_W-1 -: TAG_W];
  assign req_set  = req_addr[OFF_W +: SET_W];
  assign miss_tag = miss_addr_q[ADDR_W-1 -: TAG_W];
  assign miss_set = miss_addr_q[OFF_W +: SET_W];

  // Way0 takes priority when both ways claim the tag.
  assign hit0    = m0.valid & (m0.tag == req_tag);
  assign hit1    = m1.valid & (m1.tag == req_tag);
  assign hit     = req_valid & (hit0 | hit1);
  assign hit_way = ~hit0 & hit1;

  assign in_idle    = (state_q == ST_IDLE);
  assign in_fill    = (state_q == ST_FILL);
  assign in_meta    = (state_q == ST_META_WR);
  assign miss_start = in_idle & req_valid & ~hit;
  assign idle_hit   = in_idle & hit;
  assign last_rx    = in_fill & mem_vld & (recv_cnt == LAST_WORD);

  // Counters hold at the last word so they never wrap inside one fill.
  assign cnt_clr  = miss_start;
  assign issue_en = in_fill & mem_rd_q & (issue_cnt != LAST_WORD);
  assign recv_en  = in_fill & mem_vld & (recv_cnt != LAST_WORD);

  fill_counter #(.W(CNT_W)) u_issue_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .en  (issue_en),
    .cnt (issue_cnt)
  );

  fill_counter #(.W(CNT_W)) u_recv_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .en  (recv_en),
    .cnt (recv_cnt)
  );

  always_comb begin
    state_d     = state_q;
    victim_d    = victim_q;
    miss_addr_d = miss_addr_q;
    mem_rd_d    = mem_rd_q;
    fill_cyc_d  = fill_cyc_q;
    overrun_d   = overrun_q;
    case (state_q)
      ST_IDLE: begin
        if (miss_start) begin
          state_d     = ST_FILL;
          victim_d    = pick_victim(m0, m1);
          miss_addr_d = req_addr;
          mem_rd_d    = 1'b1;
          fill_cyc_d  = '0;
          overrun_d   = 1'b0;
        end
      end
      ST_FILL: begin
        mem_rd_d = mem_rd_q & (issue_cnt != LAST_WORD);
        if (fill_cyc_q != '1) fill_cyc_d = fill_cyc_q + 1'b1;
        // Sticky flag: memory took longer than its nominal latency.
        if (fill_cyc_q == FILL_CYC_MAX) overrun_d = 1'b1;
        if (last_rx) begin
          state_d  = ST_META_WR;
          mem_rd_d = 1'b0;
        end
      end
      ST_META_WR: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d  = ST_IDLE;
        mem_rd_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      victim_q    <= 1'b0;
      miss_addr_q <= '0;
      mem_rd_q    <= 1'b0;
      fill_cyc_q  <= '0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      victim_q    <= victim_d;
      miss_addr_q <= miss_addr_d;
      mem_rd_q    <= mem_rd_d;
      fill_cyc_q  <= fill_cyc_d;
      overrun_q   <= overrun_d;
    end
  end

  always_comb begin
    set_en = '0;
    if (!rst) set_en[req_set] = 1'b1;
  end

  // Strobes are held low while reset is asserted, whatever the state.
  assign stall    = ~rst & (miss_start | in_fill | in_meta);
  assign meta_wr0 = ~rst & ((idle_hit & ~hit_way) | (in_meta & ~victim_q));
  assign meta_wr1 = ~rst & ((idle_hit &  hit_way) | (in_meta &  victim_q));

  always_comb begin
    meta_din = '0;
    if (!rst) begin
      if (in_meta)       meta_din = mru_meta(miss_tag);
      else if (idle_hit) meta_din = mru_meta(req_tag);
    end
  end

  assign mem_rd   = ~rst & mem_rd_q;
  assign mem_addr = mem_rd ? {miss_tag, miss_set, issue_cnt, 1'b0} : '0;

  assign dwr_en   = ~rst & in_fill & mem_vld;
  assign dwr_way  = victim_q;
  assign dwr_off  = recv_cnt;
  assign dwr_data = dwr_en ? mem_data : '0;

  always_comb begin
    dbg              = '0;
    dbg.state        = state_q;
    dbg.victim       = victim_q;
    dbg.issue_cnt    = issue_cnt;
    dbg.recv_cnt     = recv_cnt;
    dbg.fill_overrun = overrun_q;
    dbg.miss_addr    = miss_addr_q;
  end

endmodule

// File: tb/tb_cache_miss_ctrl.sv
// Directed bench for cache_miss_ctrl with a metadata array model, a fixed
// latency memory responder and expected-value queues.
module tb_cache_miss_ctrl;
  import cache_miss_ctrl_pkg::*;

  localparam int MEM_LAT   = 4;
  localparam int BLK_WORDS = 8;

  logic        clk, rst;
  logic        req_valid;
  logic [15:0] req_addr;
  logic [7:0]  meta0, meta1;
  logic        hit, hit_way, stall;
  logic [63:0] set_en;
  logic        meta_wr0, meta_wr1;
  logic [7:0]  meta_din;
  logic        mem_rd;
  logic [15:0] mem_addr;
  logic        mem_vld;
  logic [15:0] mem_data;
  logic        dwr_en, dwr_way;
  logic [2:0]  dwr_off;
  logic [15:0] dwr_data;
  dbg_t        dbg;

  int n_assert = 0;
  int n_fail   = 0;
  int dwr_seen = 0;
  int cyc      = 0;
  logic stray_vld = 1'b0;

  logic [15:0] exp_addr_q[$];
  logic [19:0] exp_dwr_q[$];
  logic [8:0]  exp_meta_q[$];
  logic [31:0] pend_q[$];

  logic [7:0] meta_arr0[64];
  logic [7:0] meta_arr1[64];

  cache_miss_ctrl #(.MEM_LAT(MEM_LAT), .BLK_WORDS(BLK_WORDS)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
    .meta0(meta0), .meta1(meta1), .hit(hit), .hit_way(hit_way),
    .stall(stall), .set_en(set_en), .meta_wr0(meta_wr0), .meta_wr1(meta_wr1),
    .meta_din(meta_din), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .mem_vld(mem_vld), .mem_data(mem_data), .dwr_en(dwr_en),
    .dwr_way(dwr_way), .dwr_off(dwr_off), .dwr_data(dwr_data), .dbg(dbg)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, n_fail=%0d", n_fail);
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] mdata(input logic [15:0] a);
    return a ^ 16'hA5C3;
  endfunction

  task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", nm, obs, exp);
    end
  endtask

  // Metadata array: a written way becomes most recent, the other least recent.
  assign meta0 = meta_arr0[req_addr[9:4]];
  assign meta1 = meta_arr1[req_addr[9:4]];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) begin
        meta_arr0[i] <= 8'h00;
        meta_arr1[i] <= 8'h00;
      end
    end else if (meta_wr0) begin
      meta_arr0[req_addr[9:4]]    <= {meta_din[7:2], 1'b0, 1'b1};
      meta_arr1[req_addr[9:4]][1] <= 1'b1;
    end else if (meta_wr1) begin
      meta_arr1[req_addr[9:4]]    <= {meta_din[7:2], 1'b0, 1'b1};
      meta_arr0[req_addr[9:4]][1] <= 1'b1;
    end
  end

  // Memory: a read issued in cycle c returns its word in cycle c+MEM_LAT-1.
  initial begin
    mem_vld  = 1'b0;
    mem_data = 16'h0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (pend_q.size() > 0 && pend_q[0][31:16] == cyc[15:0]) begin
        mem_vld  = 1'b1;
        mem_data = mdata(pend_q[0][15:0]);
        void'(pend_q.pop_front());
      end else if (stray_vld) begin
        mem_vld  = 1'b1;
        mem_data = 16'hDEAD;
      end else begin
        mem_vld  = 1'b0;
        mem_data = 16'h0;
      end
      @(negedge clk);
      if (mem_rd === 1'b1 && rst === 1'b0)
        pend_q.push_back({16'(cyc + MEM_LAT - 1), mem_addr});
    end
  end

  // Scoreboard: every DUT write or read must match the head of its queue.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (mem_rd === 1'b1) begin
        chk("mem_rd_expected", 64'(exp_addr_q.size() != 0), 64'd1);
        if (exp_addr_q.size() != 0) chk("mem_addr", 64'(mem_addr), 64'(exp_addr_q.pop_front()));
      end
      if (dwr_en === 1'b1) begin
        dwr_seen++;
        chk("dwr_expected", 64'(exp_dwr_q.size() != 0), 64'd1);
        if (exp_dwr_q.size() != 0)
          chk("dwr_way_off_data", 64'({dwr_way, dwr_off, dwr_data}), 64'(exp_dwr_q.pop_front()));
      end
      if (meta_wr0 === 1'b1 || meta_wr1 === 1'b1) begin
        chk("meta_wr_onehot", 64'(meta_wr0 & meta_wr1), 64'd0);
        chk("meta_expected", 64'(exp_meta_q.size() != 0), 64'd1);
        if (exp_meta_q.size() != 0)
          chk("meta_way_din", 64'({meta_wr1, meta_din}), 64'(exp_meta_q.pop_front()));
      end
    end
  end

  // Driver: one access held until stall drops; entered and left at posedge+1.
  task automatic access(input logic [15:0] a, input logic miss, input logic way, input string nm);
    int stall_n, rd_n;
    bit done;
    logic [15:0] base, wa;
    logic [7:0]  din;
    base = {a[15:4], 4'h0};
    din  = {a[15:10], 2'b11};
    if (miss) begin
      for (int i = 0; i < BLK_WORDS; i++) begin
        wa = base + 16'(i * 2);
        exp_addr_q.push_back(wa);
        exp_dwr_q.push_back({way, 3'(i), mdata(wa)});
      end
      exp_meta_q.push_back({way, din});
    end
    exp_meta_q.push_back({way, din});
    req_addr  = a;
    req_valid = 1'b1;
    stall_n = 0;
    rd_n    = 0;
    done    = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (stall) stall_n++;
      if (mem_rd) rd_n++;
      if (!stall) done = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    chk({nm, "_done"}, 64'(done), 64'd1);
    chk({nm, "_hit"}, 64'(hit), 64'd1);
    chk({nm, "_hit_way"}, 64'(hit_way), 64'(way));
    chk({nm, "_set_en"}, set_en, 64'd1 << a[9:4]);
    chk({nm, "_stall_cycles"}, 64'(stall_n), miss ? 64'd13 : 64'd0);
    chk({nm, "_rd_cycles"}, 64'(rd_n), miss ? 64'd8 : 64'd0);
    chk({nm, "_overrun"}, 64'(dbg.fill_overrun), 64'd0);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk({nm, "_addr_q_empty"}, 64'(exp_addr_q.size()), 64'd0);
    chk({nm, "_dwr_q_empty"}, 64'(exp_dwr_q.size()), 64'd0);
    chk({nm, "_meta_q_empty"}, 64'(exp_meta_q.size()), 64'd0);
    chk({nm, "_idle"}, 64'(dbg.state), 64'(ST_IDLE));
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] ra;
    bit hit5;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_addr  = 16'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_mem_rd", 64'(mem_rd), 64'd0);
    chk("rst_dwr_en", 64'(dwr_en), 64'd0);
    chk("rst_meta_wr", 64'({meta_wr1, meta_wr0}), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_meta_din", 64'(meta_din), 64'd0);
    chk("rst_dwr_data", 64'(dwr_data), 64'd0);
    chk("rst_set_en", set_en, 64'd0);
    chk("rst_state", 64'(dbg.state), 64'(ST_IDLE));
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_counters", 64'({dbg.issue_cnt, dbg.recv_cnt}), 64'd0);
    chk("rst_victim", 64'(dbg.victim), 64'd0);
    @(posedge clk);
    #1;

    access(16'h1230, 1'b1, 1'b0, "cold_miss");
    access(16'h1236, 1'b0, 1'b0, "hit_way0");
    access(16'h2230, 1'b1, 1'b1, "fill_way1");
    access(16'h1230, 1'b0, 1'b0, "rehit_way0");
    access(16'h3230, 1'b1, 1'b1, "replace_lru_way1");
    for (int k = 0; k < 4; k++) begin
      ra = 16'h3230 | 16'($urandom_range(0, 15));
      access(ra, 1'b0, 1'b1, "rand_hit_way1");
    end
    access(16'h2230, 1'b1, 1'b0, "replace_lru_way0");

    // Stray memory return while idle
    @(negedge clk);
    stray_vld = 1'b1;
    @(posedge clk);
    #2;
    stray_vld = 1'b0;
    @(negedge clk);
    chk("stray_dwr_en", 64'(dwr_en), 64'd0);
    chk("stray_stall", 64'(stall), 64'd0);
    @(posedge clk);
    #1;
    chk("stray_state", 64'(dbg.state), 64'(ST_IDLE));

    // Reset after the fifth returned word
    for (int i = 0; i < BLK_WORDS; i++) begin
      exp_addr_q.push_back(16'h4560 + 16'(i * 2));
      if (i < 5) exp_dwr_q.push_back({1'b0, 3'(i), mdata(16'h4560 + 16'(i * 2))});
    end
    dwr_seen  = 0;
    req_addr  = 16'h4560;
    req_valid = 1'b1;
    hit5 = 1'b0;
    for (int c = 0; c < 40 && !hit5; c++) begin
      @(posedge clk);
      if (dwr_seen >= 5) hit5 = 1'b1;
    end
    chk("midfill_reached", 64'(hit5), 64'd1);
    #1;
    chk("midfill_state", 64'(dbg.state), 64'(ST_FILL));
    chk("midfill_addr_q", 64'(exp_addr_q.size()), 64'd0);
    chk("midfill_dwr_q", 64'(exp_dwr_q.size()), 64'd0);
    exp_addr_q.delete();
    exp_dwr_q.delete();
    rst       = 1'b1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("late_vld_dwr_en", 64'(dwr_en), 64'd0);
      chk("late_vld_meta_wr", 64'({meta_wr1, meta_wr0}), 64'd0);
      chk("late_vld_state", 64'(dbg.state), 64'(ST_IDLE));
    end
    @(posedge clk);
    #1;
    access(16'h4560, 1'b1, 1'b0, "refill_after_rst");

    chk("final_pending_mem", 64'(pend_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/cache_miss_ctrl.md
CACHE_MISS_CTRL -- requirements
Module: cache_miss_ctrl

Interface
REQ-001 SHALL have parameter MEM_LAT, default 4, memory read latency in cycles.
REQ-002 SHALL have parameter BLK_WORDS, default 8, 16-bit words per cache block.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 req_valid  in  1  access request present.
REQ-006 req_addr  in  16  byte address: tag [15:10], set [9:4], offset [3:0].
REQ-007 meta0, meta1  in  8 each  way0/way1 metadata for the addressed set: tag [7:2], LRU [1] (1 = least recent), valid [0].
REQ-008 hit  out  1  request hits a valid way; hit_way  out  1  matching way.
REQ-009 stall  out  1  requester holds req_addr stable while high.
REQ-010 set_en  out  64  one-hot decode of req_addr[9:4].
REQ-011 meta_wr0, meta_wr1  out  1 each  metadata write strobe per way; meta_din  out  8  {tag, 2'b11}.
REQ-012 mem_rd  out  1  memory read issue; mem_addr  out  16  word-aligned fill address.
REQ-013 mem_vld  in  1  return data valid; mem_data  in  16  returned word.
REQ-014 dwr_en  out  1  data-array write; dwr_way  out  1  victim way; dwr_off  out  3  word offset; dwr_data  out  16  = mem_data.

Function
REQ-015 hit SHALL be combinational: req_valid & ((meta0.valid & meta0.tag==req tag) | (same for way1)); way0 SHALL win if both match.
REQ-016 On hit in IDLE, the block SHALL pulse meta_wr of the hit way for one cycle with meta_din={tag,2'b11}, making it MRU.
REQ-017 States SHALL be IDLE, FILL, META_WR; IDLE->FILL on req_valid & ~hit; FILL->META_WR when the last word (receive count BLK_WORDS-1) arrives with mem_vld; META_WR->IDLE unconditionally.
REQ-018 Victim SHALL be chosen and latched on the IDLE->FILL edge: invalid way0, else invalid way1, else way with LRU=1, else way0.
REQ-019 In FILL, mem_rd SHALL assert for exactly BLK_WORDS consecutive cycles starting in the first FILL cycle, mem_addr = {req tag, set, issue_cnt, 1'b0}.
REQ-020 Each mem_vld in FILL SHALL produce one dwr_en cycle with dwr_off = receive count, dwr_way = victim; receive count SHALL increment per mem_vld.
REQ-021 Issue and receive counters SHALL be 3-bit and SHALL NOT wrap within a fill; both SHALL clear on entering FILL.
REQ-022 In META_WR, exactly one of meta_wr0/meta_wr1 (the victim) SHALL pulse for one cycle with meta_din={tag,2'b11}.
REQ-023 stall SHALL equal (IDLE & req_valid & ~hit) | FILL | META_WR; the cycle after META_WR, the held request SHALL hit.
REQ-024 With MEM_LAT=4 a miss SHALL occupy 13 cycles (8 issue + 4 latency + 1 META_WR) from the IDLE miss cycle to return to IDLE.
REQ-025 mem_vld in IDLE or META_WR SHALL be ignored; req_valid changes during FILL/META_WR SHALL be ignored.
REQ-026 meta_wr0/meta_wr1 SHALL never assert in the same cycle; no meta or data write SHALL occur when req_valid is low in IDLE.

Reset
REQ-027 On rst: state=IDLE, counters=0, victim=0; mem_rd, dwr_en, meta_wr0, meta_wr1, stall low; data outputs 0.
REQ-028 rst mid-fill SHALL abort the fill with no metadata write; late mem_vld returns SHALL be discarded.

Structure
REQ-029 Field widths (TAG_W=6, SET_W=6, OFF_W=4), metadata bit positions and state encodings SHALL live in shared header cache_defs.vh.
REQ-030 Issue/receive counting SHALL use one sub-module, fill_counter (3-bit, sync clear, enable), instanced twice.

Verification
REQ-031 Cold miss: reset, req 0x1230 -> victim way0, mem_addr 0x1230..0x123E, 8 dwr_en, meta_wr0 with meta_din 0x13, hit one cycle after META_WR.
REQ-032 Hit: after REQ-031, req 0x1236 -> hit=1, hit_way=0, stall=0, meta_wr0 pulse, no mem_rd.
REQ-033 Replacement: fill set 0x23 way0 (tag 0x04) then way1 (tag 0x08), hit way0, miss tag 0x0C -> victim way1.
REQ-034 Latency: MEM_LAT=4 miss -> stall high exactly 13 cycles; mem_rd high exactly 8.
REQ-035 Reset mid-fill: rst after 5th mem_vld -> no meta_wr, next request misses and restarts full fill.
REQ-036 Stray mem_vld in IDLE -> no dwr_en, state unchanged.
